// File: rtl/prog_sequencer_if.sv
// Bundle of the signals between prog_sequencer and the core/bench side.
// The master modport is taken by the sequencer and the slave modport by whatever drives start/core_done.
//
// cyc_valid is a one-cycle strobe with no ready. cyc_count is valid while cyc_valid is high and is held afterwards.
// start and core_done are plain levels that the sequencer samples on every rising edge.
interface prog_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             core_done;
    logic             core_reset;
    logic [1:0]       prog_sel;
    logic             busy;
    logic             all_done;
    logic             cyc_valid;
    logic [CNT_W-1:0] cyc_count;
    logic             timeout;
    logic [2:0]       dbg_state;   // sequencer FSM state, for observation only

    modport master (
        input  start, core_done,
        output core_reset, prog_sel, busy, all_done, cyc_valid, cyc_count, timeout, dbg_state
    );

    modport slave (
        output start, core_done,
        input  core_reset, prog_sel, busy, all_done, cyc_valid, cyc_count, timeout, dbg_state
    );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: runs NUM_PROGS programs on the downstream core back to back.
// For each program it holds the core in reset for HOLD_CYCLES cycles and then releases it.
// It counts the cycles until the core raises done and reports that count through cyc_valid/cyc_count.
// After the last program it parks in FINISH with a sticky all_done.
//
// Optional feature: define PROG_SEQ_WATCHDOG_EN to add a RUN-cycle watchdog.
// When a program runs WDOG_LIMIT cycles without done, the watchdog sets a sticky timeout.
// It reports cyc_count = WDOG_LIMIT and then moves on to the next program.
// Without the macro, timeout is tied low and RUN waits forever.
//
// State encoding is fixed so that dbg_state can be decoded outside:
//   0 IDLE, 1 HOLD, 2 RUN, 3 DRAIN, 4 FINISH.
module prog_sequencer #(
    parameter int NUM_PROGS   = 3,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 16,
    parameter int WDOG_LIMIT  = 4096
) (
    input logic                clk,
    input logic                reset,
    prog_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    // Hold counter wide enough to hold HOLD_CYCLES-1.
    localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [1:0]        LAST_PROG = 2'(NUM_PROGS - 1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  run_next;

    logic              core_reset_q;
    logic [1:0]        prog_sel_q;
    logic              busy_q;
    logic              all_done_q;
    logic              cyc_valid_q;
    logic [CNT_W-1:0]  cyc_count_q;

    // Run counter value for the cycle now ending, saturating at all-ones.
    // On the done edge this is "cycles spent in RUN including this one".
    assign run_next = (run_cnt == CNT_MAX) ? CNT_MAX : run_cnt + CNT_W'(1);

`ifdef PROG_SEQ_WATCHDOG_EN
    localparam logic [31:0]      WDOG_L     = 32'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] WDOG_COUNT = CNT_W'(WDOG_LIMIT);

    logic timeout_q;
    logic wdog_hit;

    // The watchdog fires on the cycle that would be the WDOG_LIMIT-th RUN cycle.
    // When done arrives on that same cycle, done wins and the program is treated as completed normally.
    assign wdog_hit = (32'(run_next) == WDOG_L);
`endif

    // Sequencer FSM. All outputs are registered here, so nothing passes combinationally from an input to an output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            run_cnt      <= '0;
            core_reset_q <= 1'b1;
            prog_sel_q   <= '0;
            busy_q       <= 1'b0;
            all_done_q   <= 1'b0;
            cyc_valid_q  <= 1'b0;
            cyc_count_q  <= '0;
`ifdef PROG_SEQ_WATCHDOG_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            cyc_valid_q <= 1'b0;

            case (state)
                // Waiting for start. The core stays in reset. From FINISH, cyc_count and timeout are left untouched.
                IDLE, FINISH: begin
                    core_reset_q <= 1'b1;
                    if (bus.start) begin
                        state      <= HOLD;
                        hold_cnt   <= '0;
                        prog_sel_q <= '0;
                        busy_q     <= 1'b1;
                        all_done_q <= 1'b0;
                    end
                end

                // Keep the core in reset for exactly HOLD_CYCLES cycles, then release it.
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state        <= RUN;
                        run_cnt      <= '0;
                        core_reset_q <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                // Core is running. Count cycles until done. start is ignored in this state.
                RUN: begin
                    run_cnt <= run_next;
                    if (bus.core_done) begin
                        state        <= DRAIN;
                        core_reset_q <= 1'b1;
                        cyc_valid_q  <= 1'b1;
                        cyc_count_q  <= run_next;
                    end
`ifdef PROG_SEQ_WATCHDOG_EN
                    else if (wdog_hit) begin
                        state        <= DRAIN;
                        core_reset_q <= 1'b1;
                        cyc_valid_q  <= 1'b1;
                        cyc_count_q  <= WDOG_COUNT;
                        timeout_q    <= 1'b1;
                    end
`endif
                end

                // One cycle with the core back in reset. Pick the next program or finish.
                DRAIN: begin
                    if (prog_sel_q == LAST_PROG) begin
                        state      <= FINISH;
                        busy_q     <= 1'b0;
                        all_done_q <= 1'b1;
                    end else begin
                        state      <= HOLD;
                        hold_cnt   <= '0;
                        prog_sel_q <= prog_sel_q + 2'd1;
                    end
                end

                default: begin
                    state        <= IDLE;
                    core_reset_q <= 1'b1;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_reset = core_reset_q;
    assign bus.prog_sel   = prog_sel_q;
    assign bus.busy       = busy_q;
    assign bus.all_done   = all_done_q;
    assign bus.cyc_valid  = cyc_valid_q;
    assign bus.cyc_count  = cyc_count_q;
    assign bus.dbg_state  = state;
`ifdef PROG_SEQ_WATCHDOG_EN
    assign bus.timeout    = timeout_q;
`else
    assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer.
// A table of three-program sequences is played through the main instance.
// A scoreboard checks every cyc_valid pulse against {prog_sel, cyc_count} pairs queued when core_done is driven.
// Hand-written sequences cover continuous done, asynchronous reset mid-RUN and counter saturation (CNT_W=4).
// They also cover the watchdog when PROG_SEQ_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_prog_sequencer;
    localparam int CNT_W = 16;
    localparam int HOLD  = 2;
    localparam int NP    = 3;
    localparam int W     = CNT_W + 2;
    localparam int NVEC  = 4;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FINISH = 3'd4;

    typedef struct packed {
        logic [2:0][15:0]      len;   // RUN cycles before done, per program
        logic [2:0][CNT_W-1:0] exp;   // expected cyc_count, per program
        logic                  poke;  // wiggle start during HOLD/RUN/DRAIN
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_sequencer_if #(.CNT_W(CNT_W)) bus ();
    prog_sequencer_if #(.CNT_W(4))     bus4 ();

    prog_sequencer #(.NUM_PROGS(NP), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W), .WDOG_LIMIT(4096))
        u_dut (.clk(clk), .reset(rst), .bus(bus));

    prog_sequencer #(.NUM_PROGS(1), .HOLD_CYCLES(HOLD), .CNT_W(4), .WDOG_LIMIT(4096))
        u_sat (.clk(clk), .reset(rst), .bus(bus4));

`ifdef PROG_SEQ_WATCHDOG_EN
    prog_sequencer_if #(.CNT_W(CNT_W)) bus_wd ();
    prog_sequencer #(.NUM_PROGS(NP), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W), .WDOG_LIMIT(64))
        u_wd (.clk(clk), .reset(rst), .bus(bus_wd));
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];

    // Compare each completion pulse of the main instance with the oldest queued expectation.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && bus.cyc_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL sb_unexpected: cyc_valid with prog_sel %0d count %0d, nothing expected",
                         bus.prog_sel, bus.cyc_count);
            end else begin
                e = exp_q.pop_front();
                check("sb_prog_sel", 32'(bus.prog_sel), 32'(e[W-1:CNT_W]));
                check("sb_cyc_count", 32'(bus.cyc_count), 32'(e[CNT_W-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic rnd_start(input logic poke);
        return poke ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // This task is called at a negedge just before the edge that samples start or done.
    // It waits for that edge, drops core_done and then counts cycles with core_reset high until the core is released.
    task automatic wait_low(input logic poke, output int n);
        n = 0;
        @(negedge clk);
        bus.core_done = 1'b0;
        while (bus.core_reset !== 1'b0) begin
            n++;
            bus.start = rnd_start(poke);
            if (n > 50) begin
                tests_run++;
                tests_failed++;
                $display("FAIL wait_low: core_reset still %b after %0d cycles", bus.core_reset, n);
                n = -1;
                return;
            end
            @(negedge clk);
        end
        bus.start = rnd_start(poke);
    endtask

    task automatic run_seq(input vec_t v);
        int n;
        bus.start = 1'b1;
        wait_low(v.poke, n);
        check("hold_len", 32'(n), HOLD);
        check("all_done_cleared", 32'(bus.all_done), 0);
        for (int p = 0; p < NP; p++) begin
            if (n < 0) return;
            check("prog_sel_run", 32'(bus.prog_sel), 32'(p));
            check("busy_run", 32'(bus.busy), 1);
            for (int i = 1; i < int'(v.len[p]); i++) begin
                @(negedge clk);
                bus.start = rnd_start(v.poke);
            end
            bus.core_done = 1'b1;
            if (v.poke) bus.start = 1'b1;  // start together with done: done wins
            exp_q.push_back({2'(p), v.exp[p]});
            if (p < NP - 1) begin
                wait_low(v.poke, n);
                check("gap_len", 32'(n), HOLD + 1);
            end else begin
                @(negedge clk);
                bus.core_done = 1'b0;
                bus.start     = 1'b0;
                check("all_done_early", 32'(bus.all_done), 0);
                check("core_reset_drain", 32'(bus.core_reset), 1);
                @(negedge clk);
                check("all_done_set", 32'(bus.all_done), 1);
                check("busy_finish", 32'(bus.busy), 0);
                check("state_finish", 32'(bus.dbg_state), 32'(ST_FINISH));
                check("timeout_low", 32'(bus.timeout), 0);
            end
        end
    endtask

    function automatic vec_t mk(input int l0, l1, l2, input int e0, e1, e2, input logic poke);
        vec_t v;
        v.len[0] = 16'(l0); v.len[1] = 16'(l1); v.len[2] = 16'(l2);
        v.exp[0] = CNT_W'(e0); v.exp[1] = CNT_W'(e1); v.exp[2] = CNT_W'(e2);
        v.poke = poke;
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        vec_t vecs[NVEC];
        int   n;
        int   r0, r1, r2;

        r0 = $urandom_range(1, 80);
        r1 = $urandom_range(1, 80);
        r2 = $urandom_range(1, 80);
        vecs[0] = mk(40, 25, 100, 40, 25, 100, 1'b0);
        vecs[1] = mk(1, 1, 1, 1, 1, 1, 1'b0);
        vecs[2] = mk(7, 300, 2, 7, 300, 2, 1'b1);
        vecs[3] = mk(r0, r1, r2, r0, r1, r2, 1'b1);

        bus.start = 1'b0; bus.core_done = 1'b0;
        bus4.start = 1'b0; bus4.core_done = 1'b0;
`ifdef PROG_SEQ_WATCHDOG_EN
        bus_wd.start = 1'b0; bus_wd.core_done = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_core_reset", 32'(bus.core_reset), 1);
        check("rst_prog_sel", 32'(bus.prog_sel), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_all_done", 32'(bus.all_done), 0);
        check("rst_cyc_valid", 32'(bus.cyc_valid), 0);
        check("rst_cyc_count", 32'(bus.cyc_count), 0);
        check("rst_timeout", 32'(bus.timeout), 0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // core_done in IDLE is ignored
        bus.core_done = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_done_ignored", 32'(bus.dbg_state), 32'(ST_IDLE));
        check("idle_core_reset", 32'(bus.core_reset), 1);
        bus.core_done = 1'b0;

        // table-driven sequences, the first from IDLE and the rest restarting from FINISH
        for (int i = 0; i < NVEC; i++) begin
            run_seq(vecs[i]);
            repeat (2) @(negedge clk);
            if (i == 0) begin
                // core_done in FINISH is ignored and cyc_count is retained
                bus.core_done = 1'b1;
                repeat (3) @(negedge clk);
                bus.core_done = 1'b0;
                check("finish_done_ignored", 32'(bus.dbg_state), 32'(ST_FINISH));
                check("finish_count_held", 32'(bus.cyc_count), 100);
            end
        end

        // core_done held high throughout: each program counts 1 and the whole sequence takes 3*(2+1+1) cycles
        exp_q.push_back({2'd0, CNT_W'(1)});
        exp_q.push_back({2'd1, CNT_W'(1)});
        exp_q.push_back({2'd2, CNT_W'(1)});
        bus.core_done = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.all_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cont_done_cycles", 32'(n), 12);
        bus.core_done = 1'b0;
        repeat (2) @(negedge clk);

        // asynchronous reset in the middle of program 1
        bus.start = 1'b1;
        wait_low(1'b0, n);
        repeat (9) @(negedge clk);
        bus.core_done = 1'b1;
        exp_q.push_back({2'd0, CNT_W'(10)});
        wait_low(1'b0, n);
        check("mid_prog_sel", 32'(bus.prog_sel), 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_core_reset", 32'(bus.core_reset), 1);
        check("async_prog_sel", 32'(bus.prog_sel), 0);
        check("async_all_done", 32'(bus.all_done), 0);
        check("async_busy", 32'(bus.busy), 0);
        check("async_cyc_count", 32'(bus.cyc_count), 0);
        check("async_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_seq(vecs[0]);

        // saturation: a 4-bit counter and done after 20 RUN cycles
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        n = 0;
        while (bus4.core_reset !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sat_hold_len", 32'(n), HOLD);
        repeat (19) @(negedge clk);
        bus4.core_done = 1'b1;
        @(negedge clk);
        bus4.core_done = 1'b0;
        check("sat_cyc_valid", 32'(bus4.cyc_valid), 1);
        check("sat_cyc_count", 32'(bus4.cyc_count), 15);
        @(negedge clk);
        check("sat_all_done", 32'(bus4.all_done), 1);

`ifdef PROG_SEQ_WATCHDOG_EN
        // watchdog: program 1 never raises done
        bus_wd.start = 1'b1;
        @(negedge clk);
        bus_wd.start = 1'b0;
        n = 0;
        while (bus_wd.core_reset !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        bus_wd.core_done = 1'b1;
        @(negedge clk);
        bus_wd.core_done = 1'b0;
        check("wd_p0_count", 32'(bus_wd.cyc_count), 5);
        n = 0;
        while (bus_wd.cyc_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("wd_p1_valid", 32'(bus_wd.cyc_valid), 1);
        check("wd_p1_prog_sel", 32'(bus_wd.prog_sel), 1);
        check("wd_p1_count", 32'(bus_wd.cyc_count), 64);
        check("wd_timeout", 32'(bus_wd.timeout), 1);
        n = 0;
        while (bus_wd.core_reset !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("wd_p2_prog_sel", 32'(bus_wd.prog_sel), 2);
        repeat (2) @(negedge clk);
        bus_wd.core_done = 1'b1;
        @(negedge clk);
        bus_wd.core_done = 1'b0;
        check("wd_p2_count", 32'(bus_wd.cyc_count), 3);
        @(negedge clk);
        check("wd_all_done", 32'(bus_wd.all_done), 1);
        bus_wd.start = 1'b1;
        @(negedge clk);
        bus_wd.start = 1'b0;
        check("wd_timeout_kept", 32'(bus_wd.timeout), 1);
        check("wd_restart_all_done", 32'(bus_wd.all_done), 0);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        tests_failed++;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "time budget exceeded");
    end

endmodule
